// File: rtl/mul_pkg.sv
// Shared RV32M multiplier types and operand helpers.
// Used by the issue controller and its product cache.
package mul_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        DRAIN = 2'b11
    } state_e;

    function automatic logic [XLEN:0] ext_a(input mul_op_e op, input logic [XLEN-1:0] rs1);
        return (op == MULHU) ? {1'b0, rs1} : {rs1[XLEN-1], rs1};
    endfunction

    function automatic logic [XLEN:0] ext_b(input mul_op_e op, input logic [XLEN-1:0] rs2);
        return ((op == MULHSU) || (op == MULHU)) ? {1'b0, rs2} : {rs2[XLEN-1], rs2};
    endfunction

    function automatic logic [XLEN-1:0] sel_word(input mul_op_e op,
                                                 input logic [2*XLEN-1:0] prod);
        return (op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_prod_cache.sv
// One-entry product cache keyed by the extended operands of the last completed multiply.
// MUL lookups match on the low operand words only, since the low product word ignores extension.
module mul_prod_cache
    import mul_pkg::*;
#(
    parameter bit FUSE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [XLEN:0]       wr_ai,
    input  logic [XLEN:0]       wr_bi,
    input  logic [2*XLEN-1:0]   wr_prod,
    input  mul_op_e             lk_op,
    input  logic [XLEN:0]       lk_ai,
    input  logic [XLEN:0]       lk_bi,
    output logic                hit,
    output logic [2*XLEN-1:0]   rd_prod
);

    logic                vld_q, vld_d;
    logic [XLEN:0]       key_ai_q, key_ai_d;
    logic [XLEN:0]       key_bi_q, key_bi_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                lo_match;
    logic                full_match;

    assign lo_match   = (key_ai_q[XLEN-1:0] == lk_ai[XLEN-1:0]) &&
                        (key_bi_q[XLEN-1:0] == lk_bi[XLEN-1:0]);
    assign full_match = (key_ai_q == lk_ai) && (key_bi_q == lk_bi);

    assign hit     = FUSE_EN && vld_q && ((lk_op == MUL) ? lo_match : full_match);
    assign rd_prod = prod_q;

    always_comb begin
        vld_d    = vld_q;
        key_ai_d = key_ai_q;
        key_bi_d = key_bi_q;
        prod_d   = prod_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (wr_en) begin
            vld_d    = 1'b1;
            key_ai_d = wr_ai;
            key_bi_d = wr_bi;
            prod_d   = wr_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            key_ai_q <= '0;
            key_bi_q <= '0;
            prod_q   <= '0;
        end else begin
            vld_q    <= vld_d;
            key_ai_q <= key_ai_d;
            key_bi_q <= key_bi_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencer between the RV32M execute stage and the 33x33 signed multiplier.
// Forms extended operands, runs the req/rdy handshake and serves repeated operands from a cache.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned TAG_W   = 5,
    parameter bit          FUSE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [XLEN-1:0]     in_rs1,
    input  logic [XLEN-1:0]     in_rs2,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic [XLEN:0]       mul_ai,
    output logic [XLEN:0]       mul_bi,
    output logic                mul_zf,
    output logic                mul_req,
    input  logic                mul_rdy,
    input  logic [2*XLEN-1:0]   mul_r
);

    mul_op_e             op_in;
    logic [XLEN:0]       ai_in;
    logic [XLEN:0]       bi_in;
    logic                zf_in;
    logic                hit;
    logic [2*XLEN-1:0]   cache_prod;
    logic                cache_wr;

    state_e              state_q, state_d;
    mul_op_e             op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [XLEN:0]       ai_q, ai_d;
    logic [XLEN:0]       bi_q, bi_d;
    logic                zf_q, zf_d;
    logic                req_q, req_d;
    logic [XLEN-1:0]     data_q, data_d;

    assign op_in = mul_op_e'(in_op);
    assign ai_in = ext_a(op_in, in_rs1);
    assign bi_in = ext_b(op_in, in_rs2);
    assign zf_in = (in_rs1 == '0) || (in_rs2 == '0);

    mul_prod_cache #(
        .FUSE_EN (FUSE_EN)
    ) u_cache (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (cache_wr),
        .wr_ai   (ai_q),
        .wr_bi   (bi_q),
        .wr_prod (mul_r),
        .lk_op   (op_in),
        .lk_ai   (ai_in),
        .lk_bi   (bi_in),
        .hit     (hit),
        .rd_prod (cache_prod)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        ai_d     = ai_q;
        bi_d     = bi_q;
        zf_d     = zf_q;
        req_d    = req_q;
        data_d   = data_q;
        cache_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && in_valid) begin
                    op_d  = op_in;
                    tag_d = in_tag;
                    ai_d  = ai_in;
                    bi_d  = bi_in;
                    zf_d  = zf_in;
                    if (hit) begin
                        data_d  = sel_word(op_in, cache_prod);
                        state_d = DONE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mul_rdy) begin
                    // req falls after the rdy cycle so a zf op cannot retrigger the multiplier
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        cache_wr = 1'b1;
                        data_d   = sel_word(op_q, mul_r);
                        state_d  = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Multiplier cannot be aborted; hold req until it finishes and drop the product
                if (mul_rdy) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= MUL;
            tag_q   <= '0;
            ai_q    <= '0;
            bi_q    <= '0;
            zf_q    <= 1'b0;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            ai_q    <= ai_d;
            bi_q    <= bi_d;
            zf_q    <= zf_d;
            req_q   <= req_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_tag   = tag_q;
    assign mul_ai    = ai_q;
    assign mul_bi    = bi_q;
    assign mul_zf    = zf_q;
    assign mul_req   = req_q;

endmodule
